// File: rtl/apb_uart_csr_pkg.sv
// Register map, bit indices and TX FSM states
// for the APB UART control/status block.
package apb_uart_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_RXDATA = 3'd3;
    localparam logic [2:0] OFF_BAUDIV = 3'd4;
    localparam logic [2:0] OFF_IRQEN  = 3'd5;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_TX_EN  = 1;
    localparam int CTRL_TX_CLR = 2;
    localparam int CTRL_RX_CLR = 3;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_OVERRUN  = 5;

    localparam int IRQ_RX_NE = 0;
    localparam int IRQ_TX_E  = 1;
    localparam int IRQ_OVR   = 2;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_WAIT  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/apb_uart_csr_if.sv
// APB3 completer bus bundle for the UART CSR block.
interface apb_uart_csr_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_csr_fifo.sv
// Synchronous FIFO with clear; a push while full is
// accepted only when a pop completes on the same edge.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push & ~clr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/apb_uart_csr.sv
// APB register block for a UART: control, status,
// TX/RX byte FIFOs, baud divisor and interrupt logic.
module apb_uart_csr
    import apb_uart_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_W     = 16,
    parameter int BAUD_RST   = 434
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_uart_csr_if.slave     apb,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              tx_en,
    output logic              rx_en,
    output logic [BAUD_W-1:0] baud_div,
    output logic              irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e         state;
    logic [2:0]        irq_en;
    logic              overrun;
    logic [2:0]        off;
    logic              acc, wr, err, ok;
    logic              sel_ctrl, sel_stat, sel_tx;
    logic              sel_rx, sel_baud, sel_irqen, sel_bad;
    logic              st_clr_ok;
    logic              tx_push, tx_pop, tx_clr;
    logic              rx_push, rx_pop, rx_clr, rx_hit;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]        tx_head, rx_head;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic [5:0]        sts;
    logic [DATA_W-1:0] rdata;
    logic              unused_ok;

    assign acc = apb.PSEL & apb.PENABLE;
    assign wr  = apb.PWRITE;
    assign off = apb.PADDR[4:2];

    assign sel_ctrl  = (off == OFF_CTRL);
    assign sel_stat  = (off == OFF_STATUS);
    assign sel_tx    = (off == OFF_TXDATA);
    assign sel_rx    = (off == OFF_RXDATA);
    assign sel_baud  = (off == OFF_BAUDIV);
    assign sel_irqen = (off == OFF_IRQEN);
    assign sel_bad   = off[2] & off[1];

    // STATUS accepts exactly one write pattern: the overrun clear
    assign st_clr_ok = (apb.PWDATA == DATA_W'(1 << ST_OVERRUN));

    assign err = sel_bad
               | (sel_tx & ~wr)
               | (sel_rx & wr)
               | (sel_stat & wr & ~st_clr_ok)
               | (sel_tx & wr & tx_full)
               | (sel_rx & ~wr & rx_empty);
    assign ok  = acc & ~err;

    assign apb.PREADY  = acc;
    assign apb.PSLVERR = acc & err & PRESETn;
    assign apb.PRDATA  = (ok & ~wr & PRESETn) ? rdata : '0;

    assign tx_clr  = ok & wr & sel_ctrl & apb.PWDATA[CTRL_TX_CLR];
    assign rx_clr  = ok & wr & sel_ctrl & apb.PWDATA[CTRL_RX_CLR];
    assign tx_push = ok & wr & sel_tx;
    assign tx_pop  = (state == T_START);
    assign rx_pop  = ok & ~wr & sel_rx;
    assign rx_hit  = rx_done & rx_en;
    assign rx_push = rx_hit;

    assign sts = {overrun, rx_empty, rx_full,
                  tx_empty, tx_full, tx_busy};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl: begin
                rdata[CTRL_RX_EN] = rx_en;
                rdata[CTRL_TX_EN] = tx_en;
            end
            sel_stat:  rdata[5:0]        = sts;
            sel_rx:    rdata[7:0]        = rx_head;
            sel_baud:  rdata[BAUD_W-1:0] = baud_div;
            sel_irqen: rdata[2:0]        = irq_en;
            default:   rdata             = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_en    <= 1'b0;
            tx_en    <= 1'b0;
            irq_en   <= '0;
            baud_div <= BAUD_W'(BAUD_RST);
            overrun  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ok & wr & sel_ctrl) begin
                rx_en <= apb.PWDATA[CTRL_RX_EN];
                tx_en <= apb.PWDATA[CTRL_TX_EN];
            end
            if (ok & wr & sel_baud)
                baud_div <= apb.PWDATA[BAUD_W-1:0];
            if (ok & wr & sel_irqen)
                irq_en <= apb.PWDATA[2:0];
            // a dropped byte outranks a same-cycle clear request
            if (rx_hit & rx_full & ~rx_pop)
                overrun <= 1'b1;
            else if (ok & wr & sel_stat)
                overrun <= 1'b0;
            irq <= |(irq_en & {overrun, tx_empty, ~rx_empty});
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= T_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            unique case (state)
                T_IDLE: begin
                    if (tx_en & ~tx_empty & ~tx_busy) begin
                        state    <= T_START;
                        tx_start <= 1'b1;
                        tx_data  <= tx_head;
                    end
                end
                T_START: begin
                    state    <= T_WAIT;
                    tx_start <= 1'b0;
                end
                T_WAIT: begin
                    if (tx_done) state <= T_IDLE;
                end
                default: begin
                    state    <= T_IDLE;
                    tx_start <= 1'b0;
                end
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .clr   (tx_clr),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (apb.PWDATA[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .clr   (rx_clr),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

    assign unused_ok = ^{apb.PADDR, apb.PWDATA, tx_cnt, rx_cnt};
endmodule

// File: tb/tb_apb_uart_csr.sv
// Directed testbench for apb_uart_csr: register access,
// TX/RX FIFO flow, error responses, interrupt and reset.
module tb_apb_uart_csr;

    logic        PCLK;
    logic        PRESETn;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_en;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int n_starts = 0;
    logic [7:0] start_q [$];

    apb_uart_csr_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_uart_csr #(
        .DATA_W(32), .ADDR_W(8), .FIFO_DEPTH(8),
        .BAUD_W(16), .BAUD_RST(434)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .apb      (bus),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_en    (tx_en),
        .rx_en    (rx_en),
        .baud_div (baud_div),
        .irq      (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (tx_start) begin
            n_starts = n_starts + 1;
            start_q.push_back(tx_data);
        end
    end

    task automatic apb_xfer(
        input  logic        w,
        input  logic [7:0]  a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        e
    );
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = w;
        bus.PADDR   = a;
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #1;
        rd = bus.PRDATA;
        e  = bus.PSLVERR;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        @(posedge PCLK); #1;
        rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        tx_done = 1'b1;
        @(posedge PCLK); #1;
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        e;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({tx_start, tx_data, irq, tx_en, rx_en} !== 12'h0) begin
            errors++;
            $display("FAIL rst_outs got %h want 0",
                     {tx_start, tx_data, irq, tx_en, rx_en});
        end
        checks++;
        if (baud_div !== 16'd434) begin
            errors++;
            $display("FAIL rst_baud got %0d want 434", baud_div);
        end
        checks++;
        if ({bus.PRDATA, bus.PSLVERR, bus.PREADY} !== 34'h0) begin
            errors++;
            $display("FAIL rst_bus got %h want 0",
                     {bus.PRDATA, bus.PSLVERR, bus.PREADY});
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 8'h10, 32'h0, rd, e);
        checks++;
        if (rd !== 32'd434 || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_baud got %0d/%b want 434/0", rd, e);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14) begin
            errors++;
            $display("FAIL rd_status got %h want 14", rd);
        end
        apb_xfer(1'b0, 8'h14, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rd_irqen got %h want 0", rd);
        end
    endtask

    task automatic test_baud();
        logic [31:0] rd;
        logic        e;
        apb_xfer(1'b1, 8'h10, 32'hABCD_1234, rd, e);
        apb_xfer(1'b0, 8'h13, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h1234 || baud_div !== 16'h1234) begin
            errors++;
            $display("FAIL baud got %h/%h want 1234",
                     rd, baud_div);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        e;
        logic [7:0]  addrs [4];
        logic        wrs   [4];
        addrs = '{8'h18, 8'h08, 8'h0C, 8'h04};
        wrs   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apb_xfer(wrs[i], addrs[i], 32'h1, rd, e);
            checks++;
            if (e !== 1'b1) begin
                errors++;
                $display("FAIL slverr_%0d got %b want 1", i, e);
            end
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14) begin
            errors++;
            $display("FAIL err_nochg got %h want 14", rd);
        end
    endtask

    task automatic test_tx_flow();
        logic [31:0] rd;
        logic        e;
        apb_xfer(1'b1, 8'h00, 32'h2, rd, e);
        apb_xfer(1'b1, 8'h08, 32'hA5, rd, e);
        apb_xfer(1'b1, 8'h08, 32'h3C, rd, e);
        for (int i = 0; i < 20 && n_starts < 1; i++)
            @(posedge PCLK);
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (n_starts !== 1 || start_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL tx_first got n=%0d d=%h want 1/a5",
                     n_starts, start_q.size() > 0 ? start_q[0] : 8'h0);
        end
        checks++;
        if (tx_data !== 8'hA5 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL tx_hold got %h/%b want a5/0",
                     tx_data, tx_start);
        end
        tx_done_pulse();
        for (int i = 0; i < 20 && n_starts < 2; i++)
            @(posedge PCLK);
        #1;
        checks++;
        if (n_starts !== 2 || start_q[1] !== 8'h3C) begin
            errors++;
            $display("FAIL tx_second got n=%0d d=%h want 2/3c",
                     n_starts, start_q.size() > 1 ? start_q[1] : 8'h0);
        end
        tx_done_pulse();
        repeat (3) @(posedge PCLK);
        #1;
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14 || n_starts !== 2) begin
            errors++;
            $display("FAIL tx_end got st=%h n=%0d want 14/2",
                     rd, n_starts);
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] rd;
        logic        e;
        int          bad;
        bad = 0;
        apb_xfer(1'b1, 8'h00, 32'h0, rd, e);
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b1, 8'h08, 32'(i), rd, e);
            if (e) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tx_fill got %0d errs want 0", bad);
        end
        apb_xfer(1'b1, 8'h08, 32'h99, rd, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL tx_ovf got %b want 1", e);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h12) begin
            errors++;
            $display("FAIL tx_full_st got %h want 12", rd);
        end
        apb_xfer(1'b1, 8'h00, 32'hF, rd, e);
        apb_xfer(1'b0, 8'h00, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL ctrl_rd got %h want 3", rd);
        end
        apb_xfer(1'b1, 8'h00, 32'h1, rd, e);
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14 || n_starts !== 2) begin
            errors++;
            $display("FAIL tx_clr got st=%h n=%0d want 14/2",
                     rd, n_starts);
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd;
        logic        e;
        for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h2C) begin
            errors++;
            $display("FAIL rx_ovr_st got %h want 2c", rd);
        end
        for (int i = 1; i <= 8; i++) begin
            apb_xfer(1'b0, 8'h0C, 32'h0, rd, e);
            checks++;
            if (rd !== 32'(i) || e !== 1'b0) begin
                errors++;
                $display("FAIL rx_rd%0d got %h/%b want %h/0",
                         i, rd, e, i);
            end
        end
        apb_xfer(1'b0, 8'h0C, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL rx_under got %h/%b want 0/1", rd, e);
        end
        apb_xfer(1'b1, 8'h04, 32'h20, rd, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr_err got %b want 0", e);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14) begin
            errors++;
            $display("FAIL ovr_clr got %h want 14", rd);
        end
    endtask

    task automatic test_rx_same_cycle();
        logic [31:0] rd;
        logic        e;
        int          bad;
        bad = 0;
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h10 + i));
        bus.PSEL   = 1'b1;
        bus.PWRITE = 1'b0;
        bus.PADDR  = 8'h0C;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        rx_data     = 8'h18;
        rx_done     = 1'b1;
        #1;
        rd = bus.PRDATA;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        rx_done     = 1'b0;
        checks++;
        if (rd !== 32'h10) begin
            errors++;
            $display("FAIL rx_sc_rd got %h want 10", rd);
        end
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h0C) begin
            errors++;
            $display("FAIL rx_sc_st got %h want 0c", rd);
        end
        for (int i = 1; i <= 8; i++) begin
            apb_xfer(1'b0, 8'h0C, 32'h0, rd, e);
            if (rd !== 32'(8'h10 + i) || e) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rx_sc_data got %0d bad want 0", bad);
        end
    endtask

    task automatic test_irq_reset();
        logic [31:0] rd;
        logic        e;
        int          n0;
        apb_xfer(1'b1, 8'h14, 32'h1, rd, e);
        rx_pulse(8'h55);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got %b want 0", irq);
        end
        @(posedge PCLK); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        apb_xfer(1'b0, 8'h0C, 32'h0, rd, e);
        @(posedge PCLK); #1;
        checks++;
        if (irq !== 1'b0 || rd !== 32'h55) begin
            errors++;
            $display("FAIL irq_clr got %b/%h want 0/55", irq, rd);
        end
        apb_xfer(1'b1, 8'h14, 32'h2, rd, e);
        apb_xfer(1'b1, 8'h00, 32'h2, rd, e);
        n0 = n_starts;
        apb_xfer(1'b1, 8'h08, 32'h77, rd, e);
        for (int i = 0; i < 20 && n_starts == n0; i++)
            @(posedge PCLK);
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (n_starts !== n0 + 1 || tx_data !== 8'h77) begin
            errors++;
            $display("FAIL wait_pre got n=%0d d=%h want %0d/77",
                     n_starts, tx_data, n0 + 1);
        end
        PRESETn = 1'b0;
        #2;
        checks++;
        if ({tx_start, tx_data, irq, tx_en, rx_en} !== 12'h0
            || baud_div !== 16'd434) begin
            errors++;
            $display("FAIL mid_rst got %h/%0d want 0/434",
                     {tx_start, tx_data, irq, tx_en, rx_en},
                     baud_div);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        apb_xfer(1'b0, 8'h04, 32'h0, rd, e);
        checks++;
        if (rd !== 32'h14 || n_starts !== n0 + 1) begin
            errors++;
            $display("FAIL post_rst got st=%h n=%0d want 14/%0d",
                     rd, n_starts, n0 + 1);
        end
        apb_xfer(1'b0, 8'h10, 32'h0, rd, e);
        checks++;
        if (rd !== 32'd434) begin
            errors++;
            $display("FAIL post_rst_baud got %0d want 434", rd);
        end
    endtask

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        rx_data     = '0;
        rx_done     = 1'b0;
        PRESETn     = 1'b0;
        test_reset();
        test_baud();
        test_errors();
        test_tx_flow();
        test_tx_full();
        test_rx_overrun();
        test_rx_same_cycle();
        test_irq_reset();
        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
